// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: initiator of the CNN layer-command handshake.
// Steps image load -> conv1 -> pool1 -> conv2 -> pool2 -> FC.
// Ports:
//   clk, reset (async, active-low), start, abort, return_ctrl[7:0]  - inputs
//   ctrl[7:0]    layer code driven into the CNN controller
//   busy         run in progress
//   done/error   sticky status of the last run
//   err_layer    layer code that was active when error was raised
//   cycle_count  busy cycles of the last run (saturating)
//   irq          one-cycle pulse on entry to DONE or ERROR
module cnn_layer_sequencer #(
    parameter int LAST_LAYER  = 5,
    parameter int LOAD_CYCLES = 4,
    parameter int CONFIRM     = 2,
    parameter int TIMEOUT_W   = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  return_ctrl,
    output logic [7:0]  ctrl,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_layer,
    output logic [31:0] cycle_count,
    output logic        irq
);

    localparam int LW = $clog2(LOAD_CYCLES + 1);
    localparam int CW = $clog2(CONFIRM + 1);
    // Watchdog fires when the counter would step onto all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state, state_n;
    logic [7:0]           ctrl_n;
    logic                 busy_n, done_n, error_n, irq_n;
    logic [2:0]           err_layer_n;
    logic [31:0]          cycle_n;
    logic [LW-1:0]        load_cnt, load_n;
    logic [CW-1:0]        conf_cnt, conf_n;
    logic [TIMEOUT_W-1:0] wd_cnt, wd_n;
    logic                 hit, fail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ctrl        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_layer   <= '0;
            cycle_count <= '0;
            irq         <= 1'b0;
            load_cnt    <= '0;
            conf_cnt    <= '0;
            wd_cnt      <= '0;
        end else begin
            state       <= state_n;
            ctrl        <= ctrl_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
            err_layer   <= err_layer_n;
            cycle_count <= cycle_n;
            irq         <= irq_n;
            load_cnt    <= load_n;
            conf_cnt    <= conf_n;
            wd_cnt      <= wd_n;
        end
    end

    always_comb begin
        state_n     = state;
        ctrl_n      = ctrl;
        busy_n      = busy;
        done_n      = done;
        error_n     = error;
        err_layer_n = err_layer;
        irq_n       = 1'b0;
        load_n      = load_cnt;
        conf_n      = conf_cnt;
        wd_n        = wd_cnt;
        fail        = 1'b0;
        hit         = (return_ctrl == ctrl);

        cycle_n = cycle_count;
        if (busy && cycle_count != 32'hFFFF_FFFF)
            cycle_n = cycle_count + 32'd1;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_n = S_LOAD;
                    ctrl_n  = 8'd0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    cycle_n = '0;
                    load_n  = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    fail = 1'b1;
                end else if (load_cnt == LW'(LOAD_CYCLES - 1)) begin
                    state_n = S_RUN;
                    ctrl_n  = 8'd1;
                    conf_n  = '0;
                    wd_n    = '0;
                end else begin
                    load_n = load_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    fail = 1'b1;
                end else if (hit && conf_cnt == CW'(CONFIRM - 1)) begin
                    // Advance beats a coincident watchdog expiry.
                    conf_n = '0;
                    wd_n   = '0;
                    if (ctrl == 8'(LAST_LAYER)) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        irq_n   = 1'b1;
                    end else begin
                        ctrl_n = ctrl + 8'd1;
                    end
                end else begin
                    conf_n = hit ? conf_cnt + 1'b1 : '0;
                    if (wd_cnt == WD_LAST)
                        fail = 1'b1;
                    else
                        wd_n = wd_cnt + 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERROR: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (fail) begin
            state_n     = S_ERROR;
            error_n     = 1'b1;
            err_layer_n = ctrl[2:0];
            busy_n      = 1'b0;
            irq_n       = 1'b1;
            ctrl_n      = 8'd0;
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed and randomized checks of the layer
// sequencer against a run-level reference model.
module tb_cnn_layer_sequencer;

    localparam int LAST  = 5;
    localparam int LOADC = 4;
    localparam int CONF  = 2;
    localparam int TW    = 4;
    localparam int WDMAX = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  return_ctrl;
    logic [7:0]  ctrl;
    logic        busy, done, error, irq;
    logic [2:0]  err_layer;
    logic [31:0] cycle_count;

    cnn_layer_sequencer #(
        .LAST_LAYER (LAST),
        .LOAD_CYCLES(LOADC),
        .CONFIRM    (CONF),
        .TIMEOUT_W  (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .return_ctrl(return_ctrl),
        .ctrl       (ctrl),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_layer  (err_layer),
        .cycle_count(cycle_count),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum int {P_IDLE, P_LOAD, P_RUN, P_DONE, P_ERR} phase_t;
    phase_t      ph;
    logic [7:0]  m_ctrl;
    logic        m_busy, m_done, m_error, m_irq;
    logic [2:0]  m_err_layer;
    logic [31:0] m_cc;
    int          load_seen, streak, stall;

    // responder: 0 manual, 1 delayed echo, 2 stuck below a layer, 3 random
    int          mode = 0;
    int          dly = 0;
    int          stuck = 0;
    bit          rnd_ctl = 0;
    logic [7:0]  hist [16];
    int          cnt3 = 0;
    int          irq_seen = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE;
        m_ctrl = '0; m_busy = 0; m_done = 0; m_error = 0;
        m_irq = 0; m_err_layer = '0; m_cc = '0;
        load_seen = 0; streak = 0; stall = 0;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 16; i++) hist[i] = '0;
    endtask

    task automatic go_error();
        ph = P_ERR;
        m_error = 1;
        m_err_layer = m_ctrl[2:0];
        m_busy = 0;
        m_irq = 1;
        m_ctrl = '0;
    endtask

    // One clock of the run-level behaviour, from the inputs about to be sampled.
    task automatic model_step();
        if (m_busy && m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
        m_irq = 0;
        case (ph)
            P_IDLE: if (start && !abort) begin
                ph = P_LOAD; m_ctrl = 0; m_busy = 1;
                m_done = 0; m_error = 0; m_cc = 0; load_seen = 0;
            end
            P_LOAD: if (abort) go_error();
            else begin
                load_seen++;
                if (load_seen == LOADC) begin
                    ph = P_RUN; m_ctrl = 1; streak = 0; stall = 0;
                end
            end
            P_RUN: if (abort) go_error();
            else begin
                streak = (return_ctrl == m_ctrl) ? streak + 1 : 0;
                if (streak == CONF) begin
                    if (m_ctrl == LAST) begin
                        ph = P_DONE; m_done = 1; m_busy = 0; m_irq = 1;
                    end else begin
                        m_ctrl = m_ctrl + 1; streak = 0; stall = 0;
                    end
                end else begin
                    stall++;
                    if (stall == WDMAX) go_error();
                end
            end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic tick();
        int r;
        case (mode)
            1: return_ctrl = hist[dly];
            2: return_ctrl = (m_ctrl >= 8'(stuck)) ? 8'(stuck - 1) : m_ctrl;
            3: begin
                r = $urandom_range(0, 3);
                if (r < 2) return_ctrl = m_ctrl;
                else if (r == 2) return_ctrl = m_ctrl - 8'd1;
                else return_ctrl = 8'($urandom_range(0, 7));
            end
            default: ;
        endcase
        if (rnd_ctl) begin
            abort = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 15) == 0);
        end
        model_step();
        @(posedge clk); #1;
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = m_ctrl;
        if (irq === 1'b1) irq_seen++;
        if (ctrl === 8'd3 && busy === 1'b1) cnt3++;
        check("ctrl", ctrl, m_ctrl);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("error", error, m_error);
        check("err_layer", err_layer, m_err_layer);
        check("irq", irq, m_irq);
        check("cycle_count", cycle_count, m_cc);
    endtask

    task automatic run_until_idle(string tag, int budget);
        int n;
        n = 0;
        while (ph != P_IDLE && n < budget) begin
            tick();
            n++;
        end
        checks++;
        assert (ph == P_IDLE) else begin
            errors++;
            $error("FAIL %s: observed no idle after %0d cycles, expected idle", tag, n);
        end
    endtask

    initial begin
        reset = 0; start = 0; abort = 0; return_ctrl = '0;
        model_reset();
        clear_hist();
        #12;
        check("rst_ctrl", ctrl, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_layer", err_layer, 0);
        check("rst_cc", cycle_count, 0);
        check("rst_irq", irq, 0);
        @(negedge clk) reset = 1;
        tick();

        // Echo after 10 cycles: 4 load + 5 layers x 12 cycles busy.
        mode = 1; dly = 10; clear_hist(); irq_seen = 0;
        start = 1; tick(); start = 0;
        for (int n = 0; n < 200 && ph != P_IDLE; n++) begin
            tick();
            if (ph == P_DONE) begin
                check("t1_cc", cycle_count, 64);
                check("t1_done", done, 1);
                check("t1_ctrl", ctrl, 5);
            end
        end
        run_until_idle("t1_idle", 5);
        tick();
        check("t1_irq_pulses", irq_seen, 1);
        check("t1_ctrl_hold", ctrl, 5);

        // Single-cycle match then drop, then two stable cycles.
        mode = 0; return_ctrl = 8'd0;
        start = 1; tick(); start = 0;
        for (int n = 0; n < 20 && m_ctrl != 8'd1; n++) tick();
        return_ctrl = 8'd1; tick();
        return_ctrl = 8'd0; tick();
        check("t2_no_adv", ctrl, 1);
        return_ctrl = 8'd1; tick(); tick();
        check("t2_adv", ctrl, 2);
        abort = 1; tick(); abort = 0;
        run_until_idle("t2_idle", 5);

        // Responder never confirms layer 3: watchdog expiry.
        mode = 2; stuck = 3; cnt3 = 0;
        start = 1; tick(); start = 0;
        for (int n = 0; n < 100 && ph != P_ERR; n++) tick();
        check("t3_error", error, 1);
        check("t3_err_layer", err_layer, 3);
        check("t3_ctrl", ctrl, 0);
        check("t3_irq", irq, 1);
        check("t3_cycles_at_3", cnt3, 15);
        tick();
        check("t3_irq_drop", irq, 0);

        // Abort at layer 2, then a clean rerun.
        mode = 1; dly = 3; clear_hist();
        start = 1; tick(); start = 0;
        for (int n = 0; n < 100 && m_ctrl != 8'd2; n++) tick();
        abort = 1; tick(); abort = 0;
        check("t4_error", error, 1);
        check("t4_err_layer", err_layer, 2);
        tick();
        clear_hist();
        start = 1; tick(); start = 0;
        check("t4_error_clr", error, 0);
        run_until_idle("t4_rerun", 200);
        check("t4_done", done, 1);

        // start while busy, start+abort in idle.
        mode = 1; dly = 2; clear_hist();
        start = 1; tick(); tick(); tick(); tick(); tick(); tick(); tick(); start = 0;
        run_until_idle("t5_run", 200);
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        check("t5_busy", busy, 0);
        check("t5_done_kept", done, 1);
        tick();

        // Async reset while ctrl=4.
        clear_hist();
        start = 1; tick(); start = 0;
        for (int n = 0; n < 100 && m_ctrl != 8'd4; n++) tick();
        #2 reset = 0;
        #1;
        model_reset();
        clear_hist();
        check("t6_ctrl", ctrl, 0);
        check("t6_busy", busy, 0);
        check("t6_cc", cycle_count, 0);
        check("t6_done", done, 0);
        @(negedge clk) reset = 1;
        tick(); tick();
        start = 1; tick(); start = 0;
        check("t6_restart", busy, 1);
        run_until_idle("t6_run", 200);

        // Randomized responder with occasional abort/start noise.
        mode = 3;
        for (int r = 0; r < 8; r++) begin
            start = 1; tick(); start = 0;
            rnd_ctl = 1;
            run_until_idle("rnd_run", 300);
            rnd_ctl = 0; start = 0; abort = 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
